// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared constants for the up/down counter display stage.
//   - SEG_BLANK / SEG_0..SEG_9 : active-high segment patterns {g,f,e,d,c,b,a}
//   - DIG_ONES / DIG_TENS      : one-hot digit enables
//   - Q_MIN / Q_MAX            : counter range end points used for wrap detection
//   - digit_sel_e              : which digit the scan is currently driving
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;

    localparam logic [1:0] DIG_ONES  = 2'b01;
    localparam logic [1:0] DIG_TENS  = 2'b10;

    localparam logic [3:0] Q_MIN     = 4'd0;
    localparam logic [3:0] Q_MAX     = 4'd15;

    typedef enum logic {
        SEL_ONES = 1'b0,
        SEL_TENS = 1'b1
    } digit_sel_e;

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
//   Combinational BCD digit to seven-segment decoder.
//   Ports:
//     digit : in  [3:0] digit value; 0-9 decode normally, 10-15 blank
//     seg   : out [6:0] segment pattern {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/updn_seg_display.sv
// -----------------------------------------------------------------------------
// updn_seg_display
//   Display stage for a 4-bit up/down counter. Samples Q every clock, flags
//   wrap-arounds (15->0 counting up, 0->15 counting down), keeps a signed wrap
//   tally modulo 16, and scans Q in decimal onto a two-digit multiplexed
//   seven-segment display (tens digit blanked when zero).
//   Parameters:
//     SCAN_DIV : cycles each digit stays enabled (2..255)
//   Ports:
//     CLK      : in   system clock, rising edge
//     RESET    : in   synchronous active-high reset
//     Q        : in   [3:0] counter value
//     UD       : in   counter direction, 1 = up, 0 = down
//     SEG      : out  [6:0] registered segment drive {g,f,e,d,c,b,a}
//     DIG      : out  [1:0] registered one-hot digit enable ([0]=ones,[1]=tens)
//     WRAP     : out  registered one-cycle wrap pulse
//     WRAP_CNT : out  [3:0] wrap tally, +1 up-wrap, -1 down-wrap, modulo 16
//
//   There are no handshakes: Q/UD are sampled unconditionally every cycle.
// -----------------------------------------------------------------------------
module updn_seg_display
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] Q,
    input  logic       UD,
    output logic [6:0] SEG,
    output logic [1:0] DIG,
    output logic       WRAP,
    output logic [3:0] WRAP_CNT
);

    localparam logic [7:0] PC_LAST = 8'(SCAN_DIV - 1);

    // Direction only matters on the edge that sees the new Q, so the live UD
    // is used and no delayed copy of it is kept.
    logic [3:0]  q_smp_q,    q_smp_d;
    logic        valid_q,    valid_d;
    logic        wrap_q,     wrap_d;
    logic [3:0]  wrap_cnt_q, wrap_cnt_d;
    logic [7:0]  pc_q,       pc_d;
    digit_sel_e  sel_q,      sel_d;
    logic [6:0]  seg_q,      seg_d;
    logic [1:0]  dig_q,      dig_d;

    logic        up_wrap;
    logic        down_wrap;
    logic        tens;
    logic [3:0]  ones;
    logic [3:0]  dec_digit;
    logic [6:0]  dec_seg;

    // valid_q suppresses a false wrap against the reset value of q_smp_q.
    assign up_wrap   = valid_q && (q_smp_q == Q_MAX) && (Q == Q_MIN) &&  UD;
    assign down_wrap = valid_q && (q_smp_q == Q_MIN) && (Q == Q_MAX) && !UD;

    // Q is at most 15, so the tens digit is a single bit.
    assign tens      = (q_smp_q >= 4'd10);
    assign ones      = q_smp_q - (tens ? 4'd10 : 4'd0);
    assign dec_digit = (sel_q == SEL_TENS) ? {3'b000, tens} : ones;

    seg7_decode u_decode (
        .digit (dec_digit),
        .seg   (dec_seg)
    );

    always_comb begin
        q_smp_d    = Q;
        valid_d    = 1'b1;
        wrap_d     = up_wrap || down_wrap;
        wrap_cnt_d = wrap_cnt_q;
        if (up_wrap) begin
            wrap_cnt_d = wrap_cnt_q + 4'd1;
        end else if (down_wrap) begin
            wrap_cnt_d = wrap_cnt_q - 4'd1;
        end

        pc_d  = pc_q + 8'd1;
        sel_d = sel_q;
        if (pc_q == PC_LAST) begin
            pc_d  = 8'd0;
            sel_d = (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
        end

        if (sel_q == SEL_TENS) begin
            dig_d = DIG_TENS;
            seg_d = tens ? dec_seg : SEG_BLANK;  // leading-zero blanking
        end else begin
            dig_d = DIG_ONES;
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_smp_q    <= 4'd0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= 4'd0;
            pc_q       <= 8'd0;
            sel_q      <= SEL_ONES;
            seg_q      <= SEG_BLANK;
            dig_q      <= DIG_ONES;
        end else begin
            q_smp_q    <= q_smp_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
            pc_q       <= pc_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

    assign SEG      = seg_q;
    assign DIG      = dig_q;
    assign WRAP     = wrap_q;
    assign WRAP_CNT = wrap_cnt_q;

endmodule

// File: tb/tb_updn_seg_display.sv
// -----------------------------------------------------------------------------
// tb_updn_seg_display
//   Bench for updn_seg_display with SCAN_DIV = 4: a hand-computed vector table,
//   hand-written corner sequences, and randomized stimulus against a
//   reference model based on edge counts and decimal arithmetic.
// -----------------------------------------------------------------------------
module tb_updn_seg_display;

    localparam int SCAN_DIV = 4;

    // ---------------- clock / reset / DUT ----------------
    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] Q;
    logic       UD;
    logic [6:0] SEG;
    logic [1:0] DIG;
    logic       WRAP;
    logic [3:0] WRAP_CNT;

    always #5 CLK = ~CLK;

    updn_seg_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Q        (Q),
        .UD       (UD),
        .SEG      (SEG),
        .DIG      (DIG),
        .WRAP     (WRAP),
        .WRAP_CNT (WRAP_CNT)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [13:0] exp_q[$];  // {seg[6:0], dig[1:0], wrap, cnt[3:0]}

    logic [6:0] seg_tbl [10];

    // reference model state
    int         m_k;          // edges since reset release
    int         m_shown;      // Q value sampled on the previous edge
    bit         m_have_prev;
    logic [3:0] m_cnt;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of one rising edge: display shows the value sampled one edge
    // earlier; scan phase follows from the number of edges since release.
    task automatic model_edge(input logic rst, input logic [3:0] q, input logic ud);
        logic [6:0] s;
        logic [1:0] d;
        logic       w;
        int         phase;
        int         qi;
        qi = int'(q);
        if (rst) begin
            m_k = 0;
            m_shown = 0;
            m_have_prev = 0;
            m_cnt = 4'd0;
            exp_q.push_back({7'h00, 2'b01, 1'b0, 4'd0});
        end else begin
            m_k++;
            phase = ((m_k - 1) / SCAN_DIV) % 2;
            if (phase == 0) begin
                d = 2'b01;
                s = seg_tbl[m_shown % 10];
            end else begin
                d = 2'b10;
                s = (m_shown / 10 == 0) ? 7'h00 : seg_tbl[m_shown / 10];
            end
            w = m_have_prev && ((m_shown == 15 && qi == 0 && ud) ||
                                (m_shown == 0 && qi == 15 && !ud));
            if (w) m_cnt = ud ? m_cnt + 4'd1 : m_cnt - 4'd1;
            exp_q.push_back({s, d, w, m_cnt});
            m_shown = qi;
            m_have_prev = 1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick(input logic rst, input logic [3:0] q, input logic ud);
        RESET = rst;
        Q     = q;
        UD    = ud;
        model_edge(rst, q, ud);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [13:0] e;
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 16'd0, 16'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, " seg"},  16'(SEG),      16'(e[13:7]));
            check({tag, " dig"},  16'(DIG),      16'(e[6:5]));
            check({tag, " wrap"}, 16'(WRAP),     16'(e[4]));
            check({tag, " cnt"},  16'(WRAP_CNT), 16'(e[3:0]));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic [3:0] q;
        logic       ud;
        logic [6:0] seg;
        logic [1:0] dig;
        logic       wrap;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [24];

    initial begin
        int pulses;
        logic [3:0] rq;
        logic       rud;
        logic       rrst;

        seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        //           rst   q      ud    seg     dig    wrap  cnt
        tbl[0]  = '{1'b1, 4'd7,  1'b1, 7'h00, 2'b01, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 4'd7,  1'b1, 7'h00, 2'b01, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 4'd7,  1'b1, 7'h00, 2'b01, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 4'd7,  1'b1, 7'h3F, 2'b01, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 4'd14, 1'b1, 7'h07, 2'b01, 1'b0, 4'd0};
        tbl[5]  = '{1'b0, 4'd15, 1'b1, 7'h66, 2'b01, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 4'd0,  1'b1, 7'h6D, 2'b01, 1'b1, 4'd1};
        tbl[7]  = '{1'b0, 4'd1,  1'b1, 7'h00, 2'b10, 1'b0, 4'd1};
        tbl[8]  = '{1'b0, 4'd1,  1'b0, 7'h00, 2'b10, 1'b0, 4'd1};
        tbl[9]  = '{1'b0, 4'd0,  1'b0, 7'h00, 2'b10, 1'b0, 4'd1};
        tbl[10] = '{1'b0, 4'd15, 1'b0, 7'h00, 2'b10, 1'b1, 4'd0};
        tbl[11] = '{1'b0, 4'd15, 1'b0, 7'h6D, 2'b01, 1'b0, 4'd0};
        tbl[12] = '{1'b0, 4'd0,  1'b0, 7'h6D, 2'b01, 1'b0, 4'd0};
        tbl[13] = '{1'b0, 4'd3,  1'b0, 7'h3F, 2'b01, 1'b0, 4'd0};
        tbl[14] = '{1'b0, 4'd9,  1'b0, 7'h4F, 2'b01, 1'b0, 4'd0};
        tbl[15] = '{1'b0, 4'd0,  1'b0, 7'h00, 2'b10, 1'b0, 4'd0};
        tbl[16] = '{1'b0, 4'd15, 1'b0, 7'h00, 2'b10, 1'b1, 4'd15};
        tbl[17] = '{1'b0, 4'd0,  1'b1, 7'h06, 2'b10, 1'b1, 4'd0};
        tbl[18] = '{1'b0, 4'd15, 1'b0, 7'h00, 2'b10, 1'b1, 4'd15};
        tbl[19] = '{1'b0, 4'd12, 1'b1, 7'h6D, 2'b01, 1'b0, 4'd15};
        tbl[20] = '{1'b0, 4'd12, 1'b1, 7'h5B, 2'b01, 1'b0, 4'd15};
        tbl[21] = '{1'b0, 4'd12, 1'b1, 7'h5B, 2'b01, 1'b0, 4'd15};
        tbl[22] = '{1'b0, 4'd12, 1'b1, 7'h5B, 2'b01, 1'b0, 4'd15};
        tbl[23] = '{1'b0, 4'd12, 1'b1, 7'h06, 2'b10, 1'b0, 4'd15};

        RESET = 1'b1;
        Q     = 4'd0;
        UD    = 1'b0;

        // ---- table-driven vectors (also cross-checked against the model) ----
        for (int i = 0; i < 24; i++) begin
            tick(tbl[i].rst, tbl[i].q, tbl[i].ud);
            check($sformatf("vec%0d seg", i),  16'(SEG),      16'(tbl[i].seg));
            check($sformatf("vec%0d dig", i),  16'(DIG),      16'(tbl[i].dig));
            check($sformatf("vec%0d wrap", i), 16'(WRAP),     16'(tbl[i].wrap));
            check($sformatf("vec%0d cnt", i),  16'(WRAP_CNT), 16'(tbl[i].cnt));
            check_model($sformatf("vec%0d model", i));
        end

        // ---- 16 consecutive up-wraps bring the tally back to zero ----
        tick(1'b1, 4'd0, 1'b1);
        check_model("ovf rst");
        tick(1'b0, 4'd15, 1'b1);
        check_model("ovf first");
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 4'd0, 1'b1);
            if (WRAP === 1'b1) pulses++;
            check_model($sformatf("ovf wrap%0d", i));
            tick(1'b0, 4'd15, 1'b1);
            if (WRAP === 1'b1) pulses++;
            check_model($sformatf("ovf hold%0d", i));
        end
        check("ovf pulses", 16'(pulses), 16'd16);
        check("ovf cnt", 16'(WRAP_CNT), 16'd0);

        // ---- reset on the same edge as an up-wrap ----
        tick(1'b0, 4'd15, 1'b1);
        check_model("midrst pre");
        tick(1'b1, 4'd0, 1'b1);
        check("midrst wrap", 16'(WRAP), 16'd0);
        check("midrst cnt", 16'(WRAP_CNT), 16'd0);
        check("midrst dig", 16'(DIG), 16'd1);
        check_model("midrst");
        // first sample after release must not wrap even though 0->15 down
        tick(1'b0, 4'd15, 1'b0);
        check("release nowrap", 16'(WRAP), 16'd0);
        check_model("release");

        // ---- randomized stimulus against the model ----
        rq  = 4'd15;
        rud = 1'b1;
        for (int i = 0; i < 600; i++) begin
            rrst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) rud = ~rud;
            case ($urandom_range(0, 3))
                0:       rq = 4'($urandom_range(0, 15));
                1:       rq = rq;
                default: rq = rud ? rq + 4'd1 : rq - 4'd1;
            endcase
            tick(rrst, rq, rud);
            check_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
